// File: rtl/pong_match_sequencer.sv
// Match-level sequencer for Pong: game state, scores, serve delay and win decision.
// Optional pause feature enabled by defining PONG_PAUSE_EN.
module pong_match_sequencer #(
    parameter int WIN_SCORE         = 7,
    parameter int SCORE_W           = 3,
    parameter int SERVE_DELAY_TICKS = 2,
    parameter int DLY_W             = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tick,
    input  logic               miss1,
    input  logic               miss2,
`ifdef PONG_PAUSE_EN
    input  logic               pause,
    output logic               paused,
`endif
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               ball_run,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [1:0]         winner,
    output logic               timer_run,
    output logic               timer_clr
);

    typedef enum logic [1:0] {
        NEW_GAME = 2'd0,
        PLAY     = 2'd1,
        NEW_BALL = 2'd2,
        OVER     = 2'd3
    } state_t;

    state_t             state_q, state_n;
    logic [SCORE_W-1:0] score1_q, score1_n, score2_q, score2_n;
    logic               dir_q, dir_n;
    logic [1:0]         win_q, win_n;
    logic [DLY_W-1:0]   cnt_q, cnt_n;
    logic               start_d;
    logic               start_evt;
    logic               live;

    assign start_evt = start & ~start_d;

`ifdef PONG_PAUSE_EN
    logic pause_d, paused_q, paused_n;
    logic pause_evt;
    assign pause_evt = pause & ~pause_d;
    assign live      = ~paused_q;
`else
    assign live      = 1'b1;
`endif

    // start_d (and pause_d) reset high so a level held through reset is not an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= NEW_GAME;
            score1_q <= '0;
            score2_q <= '0;
            dir_q    <= 1'b0;
            win_q    <= '0;
            cnt_q    <= '0;
            start_d  <= 1'b1;
`ifdef PONG_PAUSE_EN
            pause_d  <= 1'b1;
            paused_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            score1_q <= score1_n;
            score2_q <= score2_n;
            dir_q    <= dir_n;
            win_q    <= win_n;
            cnt_q    <= cnt_n;
            start_d  <= start;
`ifdef PONG_PAUSE_EN
            pause_d  <= pause;
            paused_q <= paused_n;
`endif
        end
    end

    always_comb begin
        state_n  = state_q;
        score1_n = score1_q;
        score2_n = score2_q;
        dir_n    = dir_q;
        win_n    = win_q;
        cnt_n    = cnt_q;
`ifdef PONG_PAUSE_EN
        paused_n = paused_q;
`endif
        unique case (state_q)
            NEW_GAME: begin
                score1_n = '0;
                score2_n = '0;
                win_n    = '0;
                if (start_evt) state_n = PLAY;
            end
            PLAY: begin
`ifdef PONG_PAUSE_EN
                if (pause_evt) paused_n = ~paused_q;
`endif
                if (live) begin
                    if (miss1 && !miss2) begin
                        score2_n = score2_q + SCORE_W'(1);
                        dir_n    = 1'b0;
                        if (score2_q == SCORE_W'(WIN_SCORE - 1)) begin
                            state_n = OVER;
                            win_n   = 2'd2;
                        end else begin
                            state_n = NEW_BALL;
                            cnt_n   = DLY_W'(SERVE_DELAY_TICKS);
                        end
                    end else if (miss2 && !miss1) begin
                        score1_n = score1_q + SCORE_W'(1);
                        dir_n    = 1'b1;
                        if (score1_q == SCORE_W'(WIN_SCORE - 1)) begin
                            state_n = OVER;
                            win_n   = 2'd1;
                        end else begin
                            state_n = NEW_BALL;
                            cnt_n   = DLY_W'(SERVE_DELAY_TICKS);
                        end
                    end else if (miss1 && miss2) begin
                        state_n = NEW_BALL;
                        cnt_n   = DLY_W'(SERVE_DELAY_TICKS);
                    end
                end
            end
            NEW_BALL: begin
                // zero count leaves next edge; a tick only ever decrements
                if (cnt_q == '0)  state_n = PLAY;
                else if (tick)    cnt_n   = cnt_q - DLY_W'(1);
            end
            OVER: begin
                if (start_evt) state_n = NEW_GAME;
            end
        endcase
`ifdef PONG_PAUSE_EN
        if (state_n != PLAY) paused_n = 1'b0;
`endif
    end

    always_comb begin
        state      = state_q;
        score1     = score1_q;
        score2     = score2_q;
        serve_dir  = dir_q;
        winner     = win_q;
        ball_run   = (state_q == PLAY) && live;
        ball_reset = (state_q != PLAY);
        timer_run  = (state_q == PLAY) && live;
        timer_clr  = (state_q == NEW_GAME);
`ifdef PONG_PAUSE_EN
        paused     = paused_q;
`endif
    end

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Scoreboard bench for pong_match_sequencer: directed stimulus pushes expected outputs,
// a negedge monitor pops and compares. Covers PONG_PAUSE_EN when defined.
module tb_pong_match_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b1;
    logic       tick = 1'b0;
    logic       miss1 = 1'b0;
    logic       miss2 = 1'b0;
    logic [1:0] state, winner;
    logic [2:0] score1, score2;
    logic       ball_run, ball_reset, serve_dir, timer_run, timer_clr;
    logic       paused_v;

`ifdef PONG_PAUSE_EN
    logic pause = 1'b0;
    logic paused;
    assign paused_v = paused;
`else
    assign paused_v = 1'b0;
`endif

    pong_match_sequencer #(
        .WIN_SCORE(7),
        .SCORE_W(3),
        .SERVE_DELAY_TICKS(2),
        .DLY_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .tick(tick),
        .miss1(miss1),
        .miss2(miss2),
`ifdef PONG_PAUSE_EN
        .pause(pause),
        .paused(paused),
`endif
        .state(state),
        .score1(score1),
        .score2(score2),
        .ball_run(ball_run),
        .ball_reset(ball_reset),
        .serve_dir(serve_dir),
        .winner(winner),
        .timer_run(timer_run),
        .timer_clr(timer_clr)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    string       name_q[$];
    logic [15:0] exp_q[$];

    logic [2:0] e_s1 = '0, e_s2 = '0;
    logic       e_dir = 1'b0, e_paused = 1'b0;
    logic [1:0] e_win = '0;

    // packing: state, score1, score2, ball_run, ball_reset, serve_dir, winner, timer_run, timer_clr, paused
    task automatic expect_out(input string nm, input logic [1:0] st);
        logic run, brst, tclr;
        run  = (st == 2'd1) && !e_paused;
        brst = (st != 2'd1);
        tclr = (st == 2'd0);
        name_q.push_back(nm);
        exp_q.push_back({st, e_s1, e_s2, run, brst, e_dir, e_win, run, tclr, e_paused});
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [15:0] got, e;
            string       n;
            got = {state, score1, score2, ball_run, ball_reset, serve_dir, winner,
                   timer_run, timer_clr, paused_v};
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h (st,s1,s2,run,brst,dir,win,trun,tclr,p)",
                         n, got, e);
            end
        end
    end

    task automatic cyc(input logic t, input logic m1, input logic m2);
        tick  = t;
        miss1 = m1;
        miss2 = m2;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        miss1 = 1'b0;
        miss2 = 1'b0;
    endtask

    task automatic serve(input string nm);
        cyc(1'b1, 1'b0, 1'b0); expect_out({nm, "_tick1"}, 2'd2);
        cyc(1'b1, 1'b0, 1'b0); expect_out({nm, "_tick2"}, 2'd2);
        cyc(1'b0, 1'b0, 1'b0); expect_out({nm, "_resume"}, 2'd1);
    endtask

    initial begin
        @(posedge clk); #1;
        expect_out("reset_state", 2'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // start held through reset is not an edge
        cyc(1'b0, 1'b0, 1'b0); expect_out("held_start_1", 2'd0);
        cyc(1'b0, 1'b0, 1'b0); expect_out("held_start_2", 2'd0);
        start = 1'b0;
        cyc(1'b0, 1'b0, 1'b0); expect_out("start_low", 2'd0);
        start = 1'b1;
        cyc(1'b0, 1'b0, 1'b0); expect_out("start_edge_play", 2'd1);
        cyc(1'b0, 1'b0, 1'b0); expect_out("play_hold", 2'd1);

        // miss2 -> score1, serve toward player 2, two-tick delay + 1 clk
        e_s1 = 3'd1; e_dir = 1'b1;
        cyc(1'b0, 1'b0, 1'b1); expect_out("miss2_newball", 2'd2);
        cyc(1'b0, 1'b0, 1'b0); expect_out("newball_no_tick", 2'd2);
        cyc(1'b0, 1'b1, 1'b0); expect_out("newball_miss_ignored", 2'd2);
        serve("miss2");

        // simultaneous misses: no score, direction kept
        cyc(1'b0, 1'b1, 1'b1); expect_out("both_miss", 2'd2);
        serve("both");

        // player 2 wins on the seventh miss1
        for (int i = 1; i <= 7; i++) begin
            e_s2 = 3'(i); e_dir = 1'b0;
            if (i < 7) begin
                cyc(1'b0, 1'b1, 1'b0); expect_out($sformatf("miss1_%0d", i), 2'd2);
                serve($sformatf("serve_%0d", i));
            end else begin
                e_win = 2'd2;
                cyc(1'b0, 1'b1, 1'b0); expect_out("miss1_win", 2'd3);
            end
        end
        cyc(1'b0, 1'b0, 1'b1); expect_out("over_miss_ignored", 2'd3);
        cyc(1'b1, 1'b0, 1'b0); expect_out("over_tick_hold", 2'd3);
        start = 1'b0;
        cyc(1'b0, 1'b0, 1'b0); expect_out("over_start_low", 2'd3);
        start = 1'b1;
        cyc(1'b0, 1'b0, 1'b0); expect_out("over_to_newgame", 2'd0);
        e_s1 = '0; e_s2 = '0; e_win = '0;
        cyc(1'b0, 1'b0, 1'b0); expect_out("newgame_cleared", 2'd0);
        cyc(1'b0, 1'b0, 1'b0); expect_out("newgame_needs_edge", 2'd0);

        // async reset during NEW_BALL with counter = 1
        start = 1'b0;
        cyc(1'b0, 1'b0, 1'b0); expect_out("g2_start_low", 2'd0);
        start = 1'b1;
        cyc(1'b0, 1'b0, 1'b0); expect_out("g2_play", 2'd1);
        e_s2 = 3'd1;
        cyc(1'b0, 1'b1, 1'b0); expect_out("g2_miss1", 2'd2);
        cyc(1'b1, 1'b0, 1'b0); expect_out("g2_cnt1", 2'd2);
        @(negedge clk); #1;
        rst = 1'b0;
        e_s1 = '0; e_s2 = '0; e_dir = 1'b0; e_win = '0;
        expect_out("async_reset", 2'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0); expect_out("post_reset_tick", 2'd0);
        cyc(1'b0, 1'b0, 1'b0); expect_out("post_reset_idle", 2'd0);

`ifdef PONG_PAUSE_EN
        start = 1'b0;
        cyc(1'b0, 1'b0, 1'b0); expect_out("p_start_low", 2'd0);
        start = 1'b1;
        cyc(1'b0, 1'b0, 1'b0); expect_out("p_play", 2'd1);
        pause = 1'b1; e_paused = 1'b1;
        cyc(1'b0, 1'b0, 1'b0); expect_out("pause_on", 2'd1);
        cyc(1'b0, 1'b1, 1'b0); expect_out("paused_miss_ignored", 2'd1);
        pause = 1'b0;
        cyc(1'b0, 1'b0, 1'b0); expect_out("pause_low", 2'd1);
        pause = 1'b1; e_paused = 1'b0;
        cyc(1'b0, 1'b0, 1'b0); expect_out("pause_off", 2'd1);
        e_s2 = 3'd1;
        cyc(1'b0, 1'b1, 1'b0); expect_out("resumed_miss1", 2'd2);
`endif

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
